// File: rtl/lse_accum_stream_if.sv
// Stream, result and LUT-programming bundle for lse_accum_stream.
// The block sits on the slave side; the producer/consumer pair holds the master side.
interface lse_accum_stream_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 24,
  parameter int LUT_AW = 10,
  parameter int LUT_W  = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    in_last;
  logic                    in_mode;

  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;

  logic                    lut_we;
  logic [LUT_AW-1:0]       lut_addr;
  logic [LUT_W-1:0]        lut_wdata;

  modport master (
    output in_valid, in_data, in_last, in_mode, out_ready,
           lut_we, lut_addr, lut_wdata,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, in_mode, out_ready,
           lut_we, lut_addr, lut_wdata,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lse_accum_stream.sv
// Multi-lane log-sum-exp stream accumulator: each lane folds a framed stream of
// log2-domain fixed-point operands into one LSE (or MAX-only) result per frame.
module lse_accum_stream #(
  parameter int LANES     = 4,
  parameter int DATA_W    = 24,
  parameter int FRAC_W    = 16,
  parameter int LUT_DEPTH = 1024,
  parameter int LUT_W     = 16,
  parameter int LUT_SHIFT = 10
) (
  input  logic               clk,
  input  logic               rst,
  lse_accum_stream_if.slave  bus
);

  localparam int LUT_AW = $clog2(LUT_DEPTH);
  localparam int IDX_W  = DATA_W + 1 - LUT_SHIFT;
  localparam int VEC_W  = LANES * DATA_W;

  localparam logic signed [DATA_W-1:0] NEG_INF = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

  // The correction must stay below the data range so m + corr cannot wrap past
  // DATA_W+1 bits, and the shifted distance must be wider than the LUT index.
  if (LUT_W >= DATA_W || FRAC_W >= DATA_W || LUT_DEPTH != (1 << LUT_AW) ||
      IDX_W <= LUT_AW) begin : g_bad_params
    $error("lse_accum_stream: unsupported parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic              s1_valid;
  logic              s1_last;
  logic              s1_first;
  logic [VEC_W-1:0]  s1_data;
  logic              mode_q;
  logic [VEC_W-1:0]  acc;
  logic [VEC_W-1:0]  out_data;
  logic [VEC_W-1:0]  res;
  logic              out_valid;
  logic              in_fire;
  logic              first_beat;

  logic [LUT_W-1:0]  lut_mem [LUT_DEPTH];

  assign out_valid     = (state == DONE);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.in_ready  = !out_valid && !(s1_valid && s1_last);
  assign in_fire       = bus.in_valid && bus.in_ready;

  // While IDLE, anything already in s1 is the opening beat, so only an empty s1 marks a frame start.
  assign first_beat = (state == IDLE) && !s1_valid;

  // NOTE: the LUT has no reset; its contents are software-programmed and a reset
  // port on a RAM array would block RAM inference and cost a full clear sequence.
  always_ff @(posedge clk) begin
    if (bus.lut_we) begin
      lut_mem[bus.lut_addr] <= bus.lut_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order; blocking here would create races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_first <= 1'b0;
      mode_q   <= 1'b0;
      acc      <= {LANES{NEG_INF}};
      out_data <= '0;
    end else begin
      state    <= state_next;
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_last  <= bus.in_last;
        s1_first <= first_beat;
        if (first_beat) begin
          mode_q <= bus.in_mode;
        end
      end
      if (s1_valid) begin
        acc <= res;
        if (s1_last) begin
          out_data <= res;
        end
      end
    end
  end

  // Operand payload carries no control meaning, so it is loaded without reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_data <= bus.in_data;
    end
  end

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (s1_valid)            state_next = s1_last ? DONE : ACCUM;
      ACCUM:   if (s1_valid && s1_last) state_next = DONE;
      DONE:    if (bus.out_ready)       state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic signed [DATA_W-1:0] m;
    logic        [DATA_W:0]   d;
    logic        [IDX_W-1:0]  idx;
    logic        [LUT_W-1:0]  corr;
    logic        [DATA_W:0]   sum;
    logic        [DATA_W-1:0] r;

    always_comb begin
      a    = s1_first ? NEG_INF : acc[g*DATA_W +: DATA_W];
      b    = s1_data[g*DATA_W +: DATA_W];
      m    = (a >= b) ? a : b;
      // Sign-extended difference; the larger minus the smaller is always non-negative.
      d    = (a >= b) ? ({a[DATA_W-1], a} - {b[DATA_W-1], b})
                      : ({b[DATA_W-1], b} - {a[DATA_W-1], a});
      idx  = IDX_W'(d >> LUT_SHIFT);
      corr = '0;
      if (!mode_q && (idx[IDX_W-1:LUT_AW] == '0)) begin
        corr = lut_mem[idx[LUT_AW-1:0]];
      end
      sum  = {m[DATA_W-1], m} + {{(DATA_W+1-LUT_W){1'b0}}, corr};
      if (a == NEG_INF) begin
        r = b;
      end else if (b == NEG_INF) begin
        r = a;
      end else if (sum[DATA_W] != sum[DATA_W-1]) begin
        // corr is non-negative, so the only possible overflow is upward.
        r = MAX_POS;
      end else begin
        r = sum[DATA_W-1:0];
      end
    end

    assign res[g*DATA_W +: DATA_W] = r;
  end

endmodule
